// File: rtl/temp_monitor_pkg.sv
// ---------------------------------------------------------------------------
// temp_monitor_pkg
// Shared types and default constants for the temperature supervisor.
//   estado_t : supervisor state as seen on estado_actual
//   clase_t  : per-sample classification against the comfort band
// ---------------------------------------------------------------------------
package temp_monitor_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        BAJO   = 2'b01,
        ALTO   = 2'b10,
        ALERTA = 2'b11
    } estado_t;

    typedef enum logic [1:0] {
        C_NORMAL,
        C_COLD,
        C_HOT
    } clase_t;

    localparam int T_LOW_DEF   = 180;
    localparam int T_HIGH_DEF  = 259;
    localparam int PERSIST_DEF = 5;
    localparam int HYST_DEF    = 10;

endpackage

// File: rtl/temp_monitor_core_persist_counter.sv
// ---------------------------------------------------------------------------
// persist_counter
// Counts consecutive same-side out-of-band samples, saturating at PERSIST-1.
// Ports:
//   clk, arst   : clock, asynchronous active-high reset (count -> 0)
//   i_clr       : count -> 0 (highest priority)
//   i_restart   : count -> 1 (first sample on a new side)
//   i_inc       : count + 1, holds at PERSIST-1
//   o_at_max    : count == PERSIST-1
// ---------------------------------------------------------------------------
module persist_counter
    import temp_monitor_pkg::*;
#(
    parameter int PERSIST = PERSIST_DEF
) (
    input  logic clk,
    input  logic arst,
    input  logic i_clr,
    input  logic i_restart,
    input  logic i_inc,
    output logic o_at_max
);

    localparam int            CW    = $clog2(PERSIST);
    localparam logic [CW-1:0] C_MAX = CW'(PERSIST - 1);

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= CW'(1);
        end else if (i_inc && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_max = (r_count == C_MAX);

endmodule

// File: rtl/temp_monitor_core.sv
// ---------------------------------------------------------------------------
// temp_monitor_core
// Temperature supervisor: classifies each sample (tenths of degC) as COLD,
// NORMAL or HOT, drives heater/fan and raises alerta after PERSIST
// consecutive same-side out-of-band samples. State updates one clock after
// the sample; outputs decode from registered state only.
// Ports:
//   clk            : clock, rising edge
//   arst           : asynchronous active-high reset
//   temp_entrada   : temperature sample, valid every cycle
//   alerta         : 1 while in ALERTA
//   calefactor     : heater on (BAJO, or ALERTA on the cold side)
//   ventilador     : fan on (ALTO, or ALERTA on the hot side)
//   estado_actual  : 00 NORMAL, 01 BAJO, 10 ALTO, 11 ALERTA
// Configuration:
//   TEMP_HYST_EN   : when defined, leaving a cold state needs temp >= T_LOW+HYST
//                    and leaving a hot state needs temp <= T_HIGH-HYST; samples
//                    in the hysteresis gap hold state and count.
// ---------------------------------------------------------------------------
module temp_monitor_core
    import temp_monitor_pkg::*;
#(
    parameter int W_TEMP  = 10,
    parameter int T_LOW   = T_LOW_DEF,
    parameter int T_HIGH  = T_HIGH_DEF,
    parameter int PERSIST = PERSIST_DEF,
    parameter int HYST    = HYST_DEF
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [W_TEMP-1:0] temp_entrada,
    output logic              alerta,
    output logic              calefactor,
    output logic              ventilador,
    output logic [1:0]        estado_actual
);

`ifdef TEMP_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    localparam logic [W_TEMP-1:0] C_LOW       = W_TEMP'(T_LOW);
    localparam logic [W_TEMP-1:0] C_HIGH      = W_TEMP'(T_HIGH);
    localparam logic [W_TEMP-1:0] C_LOW_EXIT  = W_TEMP'(T_LOW + HYST);
    localparam logic [W_TEMP-1:0] C_HIGH_EXIT = W_TEMP'(T_HIGH - HYST);

    estado_t r_estado;
    logic    r_side_hot;   // 0 = cold side, 1 = hot side

    clase_t  w_clase;
    logic    w_in_cold;
    logic    w_in_hot;
    logic    w_hold;
    logic    w_side_change;
    logic    w_at_max;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_clase = C_NORMAL;
        if (temp_entrada < C_LOW) begin
            w_clase = C_COLD;
        end else if (temp_entrada > C_HIGH) begin
            w_clase = C_HOT;
        end
    end

    assign w_in_cold = (r_estado == BAJO) || ((r_estado == ALERTA) && !r_side_hot);
    assign w_in_hot  = (r_estado == ALTO) || ((r_estado == ALERTA) &&  r_side_hot);

    // Hysteresis gap: in-band sample that is not yet far enough from the
    // threshold we are recovering from. Constant-folds to 0 when disabled.
    assign w_hold = HYST_ON &&
                    ((w_in_cold && (temp_entrada >= C_LOW)  && (temp_entrada < C_LOW_EXIT)) ||
                     (w_in_hot  && (temp_entrada <= C_HIGH) && (temp_entrada > C_HIGH_EXIT)));

    assign w_side_change = ((w_clase == C_COLD) &&  r_side_hot) ||
                           ((w_clase == C_HOT)  && !r_side_hot);

    persist_counter #(
        .PERSIST (PERSIST)
    ) u_persist (
        .clk       (clk),
        .arst      (arst),
        .i_clr     ((w_clase == C_NORMAL) && !w_hold),
        .i_restart ((w_clase != C_NORMAL) &&  w_side_change),
        .i_inc     ((w_clase != C_NORMAL) && !w_side_change),
        .o_at_max  (w_at_max)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_estado   <= NORMAL;
            r_side_hot <= 1'b0;
        end else if (!w_hold) begin
            case (w_clase)
                C_COLD: begin
                    // ALERTA only if this continues a cold run that already
                    // reached the limit; a side change always lands in BAJO.
                    r_estado   <= (!r_side_hot && (w_at_max || (r_estado == ALERTA))) ? ALERTA : BAJO;
                    r_side_hot <= 1'b0;
                end
                C_HOT: begin
                    r_estado   <= (r_side_hot && (w_at_max || (r_estado == ALERTA))) ? ALERTA : ALTO;
                    r_side_hot <= 1'b1;
                end
                default: begin
                    r_estado <= NORMAL;
                end
            endcase
        end
    end

    assign estado_actual = r_estado;
    assign alerta        = (r_estado == ALERTA);
    assign calefactor    = (r_estado == BAJO) || ((r_estado == ALERTA) && !r_side_hot);
    assign ventilador    = (r_estado == ALTO) || ((r_estado == ALERTA) &&  r_side_hot);

endmodule

// File: tb/tb_temp_monitor_core.sv
// ---------------------------------------------------------------------------
// tb_temp_monitor_core
// Directed-vector bench for temp_monitor_core (default build, no hysteresis).
// Each step drives one sample on the falling edge and checks state and
// actuators 1 ns after the next rising edge.
// ---------------------------------------------------------------------------
module tb_temp_monitor_core;

    logic       clk;
    logic       arst;
    logic [9:0] temp_entrada;
    logic       alerta;
    logic       calefactor;
    logic       ventilador;
    logic [1:0] estado_actual;

    int n_total = 0;
    int n_bad   = 0;

    // Expected actuator patterns {alerta, calefactor, ventilador}
    localparam logic [2:0] ACT_OFF    = 3'b000;
    localparam logic [2:0] ACT_HEAT   = 3'b010;
    localparam logic [2:0] ACT_FAN    = 3'b001;
    localparam logic [2:0] ACT_AL_CLD = 3'b110;
    localparam logic [2:0] ACT_AL_HOT = 3'b101;

    temp_monitor_core dut (
        .clk           (clk),
        .arst          (arst),
        .temp_entrada  (temp_entrada),
        .alerta        (alerta),
        .calefactor    (calefactor),
        .ventilador    (ventilador),
        .estado_actual (estado_actual)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input int t, input logic [1:0] exp_st, input logic [2:0] exp_act);
        @(negedge clk);
        temp_entrada = 10'(t);
        @(posedge clk);
        #1;
        check({tag, "_estado"}, {6'd0, estado_actual}, {6'd0, exp_st});
        check({tag, "_act"}, {5'd0, alerta, calefactor, ventilador}, {5'd0, exp_act});
    endtask

    initial begin
        arst         = 1'b1;
        temp_entrada = 10'd220;
        repeat (2) @(posedge clk);
        #1;
        check("reset_estado", {6'd0, estado_actual}, 8'h00);
        check("reset_act", {5'd0, alerta, calefactor, ventilador}, 8'h00);
        @(negedge clk);
        arst = 1'b0;

        // In-band samples including both band edges
        step("norm_220", 220, 2'b00, ACT_OFF);
        step("norm_180", 180, 2'b00, ACT_OFF);
        step("norm_259", 259, 2'b00, ACT_OFF);
        step("norm_200", 200, 2'b00, ACT_OFF);

        // Immediate classification
        step("cold_150", 150, 2'b01, ACT_HEAT);
        step("hot_300",  300, 2'b10, ACT_FAN);

        // Cold persistence after a side change: alert on 5th, stays on 6th/7th
        step("cp1", 150, 2'b01, ACT_HEAT);
        step("cp2", 140, 2'b01, ACT_HEAT);
        step("cp3", 170, 2'b01, ACT_HEAT);
        step("cp4", 100, 2'b01, ACT_HEAT);
        step("cp5", 120, 2'b11, ACT_AL_CLD);
        step("cp6", 160, 2'b11, ACT_AL_CLD);
        step("cp7",   0, 2'b11, ACT_AL_CLD);

        // One in-band sample recovers
        step("recover", 220, 2'b00, ACT_OFF);

        // 4 cold then side change to hot: alert only on 5th hot sample
        step("rc1", 179, 2'b01, ACT_HEAT);
        step("rc2", 150, 2'b01, ACT_HEAT);
        step("rc3", 150, 2'b01, ACT_HEAT);
        step("rc4", 150, 2'b01, ACT_HEAT);
        step("rh1", 260, 2'b10, ACT_FAN);
        step("rh2", 300, 2'b10, ACT_FAN);
        step("rh3", 300, 2'b10, ACT_FAN);
        step("rh4", 300, 2'b10, ACT_FAN);
        step("rh5", 300, 2'b11, ACT_AL_HOT);
        step("rh6", 1023, 2'b11, ACT_AL_HOT);

        // Side change out of hot alert drops straight to BAJO
        step("flip_cold", 100, 2'b01, ACT_HEAT);

        // Hot persistence from NORMAL
        step("hn", 220, 2'b00, ACT_OFF);
        for (int i = 1; i <= 6; i++) begin
            step($sformatf("hp%0d", i), 300, (i >= 5) ? 2'b11 : 2'b10,
                 (i >= 5) ? ACT_AL_HOT : ACT_FAN);
        end

        // Reset mid-alert clears outputs without a clock edge
        @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        check("arst_async_estado", {6'd0, estado_actual}, 8'h00);
        check("arst_async_act", {5'd0, alerta, calefactor, ventilador}, 8'h00);
        @(negedge clk);
        arst = 1'b0;

        // Count and side restarted by reset: a fresh cold run needs 5 samples
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("pr%0d", i), 50, (i == 5) ? 2'b11 : 2'b01,
                 (i == 5) ? ACT_AL_CLD : ACT_HEAT);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
